wb_calram_accum: RTL



---
 rtl/wb_calram_accum_pkg.sv | 22 ++
 rtl/calram_accum_chan.sv | 109 ++++++++++
 rtl/wb_calram_accum.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/wb_calram_accum_pkg.sv
// rtl/wb_calram_accum_pkg.sv - shared state encoding, register map and CTRL bit positions
package wb_calram_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_TARGET = 3'd1;
  localparam logic [2:0] REG_THRESH = 3'd2;
  localparam logic [2:0] REG_SAT    = 3'd3;
  localparam logic [2:0] REG_ROLLS0 = 3'd4;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_MODE  = 2;
  localparam int CTRL_DONE  = 3;

endpackage

// File: rtl/calram_accum_chan.sv
// rtl/calram_accum_chan.sv - one channel: accumulator RAM, counters, RMW pipeline, saturation
module calram_accum_chan
  import wb_calram_accum_pkg::*;
#(
  parameter int SAMPLE_BITS = 12,
  parameter int DEPTH_BITS  = 12,
  parameter int ACC_BITS    = 27
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   run,
  input  logic                   clear,
  input  logic                   start_run,
  input  logic                   start_clear,
  input  logic                   mode,
  input  logic [DEPTH_BITS-1:0]  clr_addr,
  input  logic [SAMPLE_BITS-1:0] thresh,
  input  logic [31:0]            target,
  input  logic [SAMPLE_BITS-1:0] smp_dat,
  input  logic                   smp_wr,
  input  logic [DEPTH_BITS-1:0]  wb_addr,
  input  logic                   wb_we,
  input  logic [ACC_BITS-1:0]    wb_wdata,
  output logic [ACC_BITS-1:0]    rd_data,
  output logic                   sat,
  output logic [31:0]            rolls
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [ACC_BITS-1:0]    mem [DEPTH];
  logic [DEPTH_BITS-1:0]  addr_q;
  logic                   reached, accept;
  logic                   s1_valid, s2_valid;
  logic [DEPTH_BITS-1:0]  s1_addr, s2_addr;
  logic [SAMPLE_BITS-1:0] s1_smp;
  logic [ACC_BITS-1:0]    s2_new, rmw_old_q, old_val, inc, new_val;
  logic [ACC_BITS:0]      sum;
  logic                   we;
  logic [DEPTH_BITS-1:0]  waddr;
  logic [ACC_BITS-1:0]    wdata;

  // A channel that has completed its quota ignores further strobes
  assign reached = (rolls == target);
  assign accept  = run & smp_wr & ~reached;

  // Address counter wraps DEPTH-1 -> 0; each wrap is one completed roll
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q <= '0;
      rolls  <= '0;
    end else if (start_run || start_clear) begin
      addr_q <= '0;
      rolls  <= '0;
    end else if (accept) begin
      addr_q <= addr_q + DEPTH_BITS'(1);
      if (&addr_q) rolls <= rolls + 32'd1;
    end
  end

  // RMW pipeline registers: stage 1 holds the read, stage 2 the pending write
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_smp   <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_new   <= '0;
    end else begin
      s1_valid <= accept;
      s1_addr  <= addr_q;
      s1_smp   <= smp_dat;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_new   <= new_val;
    end
  end

  // Modify stage: forward the in-flight word, add sample or threshold hit, clamp on overflow
  always_comb begin
    old_val = (s2_valid && (s2_addr == s1_addr)) ? s2_new : rmw_old_q;
    inc     = mode ? ACC_BITS'(s1_smp > thresh) : ACC_BITS'(s1_smp);
    sum     = {1'b0, old_val} + {1'b0, inc};
    new_val = sum[ACC_BITS] ? '1 : sum[ACC_BITS-1:0];
  end

  // Sticky saturation flag, cleared only by a clear command
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                       sat <= 1'b0;
    else if (start_clear)               sat <= 1'b0;
    else if (s1_valid && sum[ACC_BITS]) sat <= 1'b1;
  end

  // Single write port shared by clear sweep, RMW write-back and bus writes
  always_comb begin
    we    = clear | s2_valid | wb_we;
    waddr = clear ? clr_addr : (s2_valid ? s2_addr : wb_addr);
    wdata = clear ? '0 : (s2_valid ? s2_new : wb_wdata);
  end

  // RAM array: RMW read port with write-through, independent bus read port
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    rmw_old_q <= (we && (waddr == addr_q)) ? wdata : mem[addr_q];
    rd_data   <= mem[wb_addr];
  end

endmodule

// File: rtl/wb_calram_accum.sv
// rtl/wb_calram_accum.sv - WISHBONE decode, control registers and run/clear FSM
module wb_calram_accum
  import wb_calram_accum_pkg::*;
#(
  parameter int NUM_CH      = 24,
  parameter int SAMPLE_BITS = 12,
  parameter int DEPTH_BITS  = 12,
  parameter int ACC_BITS    = 27,
  parameter int CH_BITS     = 5,
  parameter int WB_ADR_BITS = 19
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wb_cyc_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_we_i,
  input  logic [WB_ADR_BITS-1:0]        wb_adr_i,
  input  logic [31:0]                   wb_dat_i,
  input  logic [3:0]                    wb_sel_i,
  output logic [31:0]                   wb_dat_o,
  output logic                          wb_ack_o,
  output logic                          wb_err_o,
  output logic                          wb_rty_o,
  input  logic [NUM_CH*SAMPLE_BITS-1:0] smp_dat_i,
  input  logic [NUM_CH-1:0]             smp_wr_i,
  output logic                          done_o
);

  state_e                 state_q, state_d;
  logic [DEPTH_BITS-1:0]  clr_cnt_q, word;
  logic [CH_BITS-1:0]     ch, rd_ch_q;
  logic [2:0]             reg_idx;
  logic                   is_ram, is_ctl, req, busy, ram_wr_bad, ram_we, ctrl_wr;
  logic                   start_run, start_clear, all_reached, mode_q, rd_is_ram_q;
  logic [31:0]            target_q, target_eff, reg_rdata, reg_rdata_q;
  logic [31:0]            rolls [NUM_CH];
  logic [SAMPLE_BITS-1:0] thresh_q;
  logic [NUM_CH-1:0]      sat_all, ch_we;
  logic [ACC_BITS-1:0]    rd_data [NUM_CH];
  logic [ACC_BITS-1:0]    ram_rd;
  logic                   unused_ok;

  assign word       = wb_adr_i[2 +: DEPTH_BITS];
  assign ch         = wb_adr_i[2+DEPTH_BITS +: CH_BITS];
  assign reg_idx    = 3'(word);
  assign is_ram     = (ch < CH_BITS'(NUM_CH));
  assign is_ctl     = (ch == CH_BITS'(NUM_CH));
  assign req        = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign busy       = (state_q == RUN) || (state_q == CLEAR);
  assign ram_wr_bad = req & wb_we_i & is_ram & busy;
  assign ram_we     = req & wb_we_i & is_ram & ~busy;
  assign ctrl_wr    = req & wb_we_i & is_ctl & (reg_idx == REG_CTRL);
  assign target_eff = (target_q == 32'd0) ? 32'd1 : target_q;
  assign done_o     = (state_q == DONE);
  assign wb_rty_o   = 1'b0;
  assign unused_ok  = ^{wb_sel_i, wb_adr_i};

  // Next-state logic and one-cycle start strobes for the channels
  always_comb begin
    state_d     = state_q;
    start_run   = 1'b0;
    start_clear = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (ctrl_wr && wb_dat_i[CTRL_CLEAR]) begin
          state_d     = CLEAR;
          start_clear = 1'b1;
        end else if (ctrl_wr && wb_dat_i[CTRL_RUN]) begin
          state_d   = RUN;
          start_run = 1'b1;
        end
      end
      CLEAR:   if (&clr_cnt_q) state_d = IDLE;
      RUN: begin
        if (ctrl_wr && !wb_dat_i[CTRL_RUN]) state_d = IDLE;
        else if (all_reached)               state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, clear sweep address and latched mode
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_clear)             clr_cnt_q <= '0;
      else if (state_q == CLEAR)   clr_cnt_q <= clr_cnt_q + DEPTH_BITS'(1);
      if (start_run || start_clear) mode_q <= wb_dat_i[CTRL_MODE];
    end
  end

  // Writable configuration registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      target_q <= '0;
      thresh_q <= '0;
    end else if (req && wb_we_i && is_ctl) begin
      if (reg_idx == REG_TARGET) target_q <= wb_dat_i;
      if (reg_idx == REG_THRESH) thresh_q <= wb_dat_i[SAMPLE_BITS-1:0];
    end
  end

  // Control-space read mux, captured in the request cycle
  always_comb begin
    reg_rdata = '0;
    if (is_ctl) begin
      case (reg_idx)
        REG_CTRL:   reg_rdata = {28'd0, done_o, mode_q, state_q == CLEAR, state_q == RUN};
        REG_TARGET: reg_rdata = target_q;
        REG_THRESH: reg_rdata = 32'(thresh_q);
        REG_SAT:    reg_rdata = 32'(sat_all);
        REG_ROLLS0: reg_rdata = rolls[0];
        default:    reg_rdata = '0;
      endcase
    end
  end

  // Bus response: ack or err one cycle after the strobe, read select registered with it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      rd_is_ram_q <= 1'b0;
      rd_ch_q     <= '0;
      reg_rdata_q <= '0;
    end else begin
      wb_ack_o    <= req & ~ram_wr_bad;
      wb_err_o    <= ram_wr_bad;
      rd_is_ram_q <= is_ram;
      rd_ch_q     <= ch;
      reg_rdata_q <= reg_rdata;
    end
  end

  // Channel read-data select and completion detect across all channels
  always_comb begin
    ram_rd      = '0;
    all_reached = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_q == CH_BITS'(i)) ram_rd = rd_data[i];
      if (rolls[i] != target_eff) all_reached = 1'b0;
    end
  end

  assign wb_dat_o = rd_is_ram_q ? 32'(ram_rd) : reg_rdata_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = ram_we && (ch == CH_BITS'(i));
    calram_accum_chan #(
      .SAMPLE_BITS (SAMPLE_BITS),
      .DEPTH_BITS  (DEPTH_BITS),
      .ACC_BITS    (ACC_BITS)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .run         (state_q == RUN),
      .clear       (state_q == CLEAR),
      .start_run   (start_run),
      .start_clear (start_clear),
      .mode        (mode_q),
      .clr_addr    (clr_cnt_q),
      .thresh      (thresh_q),
      .target      (target_eff),
      .smp_dat     (smp_dat_i[i*SAMPLE_BITS +: SAMPLE_BITS]),
      .smp_wr      (smp_wr_i[i]),
      .wb_addr     (word),
      .wb_we       (ch_we[i]),
      .wb_wdata    (wb_dat_i[ACC_BITS-1:0]),
      .rd_data     (rd_data[i]),
      .sat         (sat_all[i]),
      .rolls       (rolls[i])
    );
  end

endmodule
